// File: rtl/doom_pkg.sv
// Shared heading codes, controller states and per-heading step helpers.
// The ray caster decodes the same DIR_* values.
package doom_pkg;

   localparam int COORD_W_DEF = 4;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_E = 2'd1,
      DIR_S = 2'd2,
      DIR_W = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_RENDER = 2'd2
   } state_t;

   // Unit step along x for a heading: E is +1, W is -1.
   function automatic logic signed [1:0] delta_x(input logic [1:0] d);
      case (d)
         DIR_E:   return 2'sd1;
         DIR_W:   return -2'sd1;
         default: return 2'sd0;
      endcase
   endfunction

   // Unit step along y for a heading: N is -1 (screen-up), S is +1.
   function automatic logic signed [1:0] delta_y(input logic [1:0] d);
      case (d)
         DIR_N:   return -2'sd1;
         DIR_S:   return 2'sd1;
         default: return 2'sd0;
      endcase
   endfunction

   // True when a step from the current cell in heading d would leave the map.
   function automatic logic off_map(input logic [1:0] d, input logic at_x0,
                                    input logic at_xmax, input logic at_y0,
                                    input logic at_ymax);
      case (d)
         DIR_N:   return at_y0;
         DIR_E:   return at_xmax;
         DIR_S:   return at_ymax;
         default: return at_x0;
      endcase
   endfunction

endpackage

// File: rtl/player_controller_if.sv
// Buttons, map-read handshake, render handshake and player state outputs.
// master = controller side, slave = environment (map store, ray caster, buttons).
interface player_controller_if #(parameter int COORD_W = 4);

   logic               btn_fwd;
   logic               btn_ccw;
   logic               btn_cw;

   logic               map_rd_req;
   logic [COORD_W-1:0] map_rd_x;
   logic [COORD_W-1:0] map_rd_y;
   logic               map_rd_valid;
   logic               map_rd_wall;

   logic               render_req;
   logic               render_ack;

   logic [COORD_W-1:0] pos_x;
   logic [COORD_W-1:0] pos_y;
   logic [1:0]         dir;
   logic               busy;
   logic               bump;

   modport master (
      input  btn_fwd, btn_ccw, btn_cw,
      input  map_rd_valid, map_rd_wall, render_ack,
      output map_rd_req, map_rd_x, map_rd_y, render_req,
      output pos_x, pos_y, dir, busy, bump
   );

   modport slave (
      output btn_fwd, btn_ccw, btn_cw,
      output map_rd_valid, map_rd_wall, render_ack,
      input  map_rd_req, map_rd_x, map_rd_y, render_req,
      input  pos_x, pos_y, dir, busy, bump
   );

endinterface

// File: rtl/player_controller_btn_edge.sv
// Level to single-cycle rising-edge pulse; both the previous level and the
// pulse are registered so a held button fires exactly once.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic pulse
);

   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         prev  <= level;
         pulse <= level & ~prev;
      end
   end

endmodule

// File: rtl/player_controller.sv
// Player state sequencer: button edges -> rotate or collision-checked move,
// then one render handshake per state change.
module player_controller
   import doom_pkg::*;
#(
   parameter int COORD_W   = COORD_W_DEF,
   parameter int START_X   = 1,
   parameter int START_Y   = 1,
   parameter int START_DIR = 0
) (
   input logic                 clk,
   input logic                 rst,
   player_controller_if.master bus
);

   localparam logic [COORD_W-1:0] MAX_C = '1;

   state_t             state;
   logic [COORD_W-1:0] pos_x, pos_y;
   logic [1:0]         dir_q;
   logic               map_req_q;
   logic [COORD_W-1:0] map_x_q, map_y_q;
   logic               render_req_q;
   logic               bump_q;

   // Index 0 = fwd, 1 = ccw, 2 = cw; lowest index wins on a tie.
   logic [2:0] lvl, pls;
   assign lvl = {bus.btn_cw, bus.btn_ccw, bus.btn_fwd};

   btn_edge u_btn [2:0] (
      .clk   (clk),
      .rst   (rst),
      .level (lvl),
      .pulse (pls)
   );

   logic signed [1:0]  dx, dy;
   logic [COORD_W-1:0] tgt_x, tgt_y;
   logic               blocked;

   assign dx      = delta_x(dir_q);
   assign dy      = delta_y(dir_q);
   assign tgt_x   = pos_x + COORD_W'(dx);
   assign tgt_y   = pos_y + COORD_W'(dy);
   assign blocked = off_map(dir_q, pos_x == '0, pos_x == MAX_C,
                            pos_y == '0, pos_y == MAX_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_RENDER;
         pos_x        <= COORD_W'(START_X);
         pos_y        <= COORD_W'(START_Y);
         dir_q        <= 2'(START_DIR);
         map_req_q    <= 1'b0;
         map_x_q      <= '0;
         map_y_q      <= '0;
         render_req_q <= 1'b0;
         bump_q       <= 1'b0;
      end else begin
         bump_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (pls[0]) begin
                  // Off-map moves never reach the map store or the renderer.
                  if (blocked) begin
                     bump_q <= 1'b1;
                  end else begin
                     map_req_q <= 1'b1;
                     map_x_q   <= tgt_x;
                     map_y_q   <= tgt_y;
                     state     <= ST_CHECK;
                  end
               end else if (pls[1]) begin
                  dir_q        <= dir_q - 2'd1;
                  render_req_q <= 1'b1;
                  state        <= ST_RENDER;
               end else if (pls[2]) begin
                  dir_q        <= dir_q + 2'd1;
                  render_req_q <= 1'b1;
                  state        <= ST_RENDER;
               end
            end
            ST_CHECK: begin
               if (bus.map_rd_valid) begin
                  map_req_q <= 1'b0;
                  if (bus.map_rd_wall) begin
                     bump_q <= 1'b1;
                     state  <= ST_IDLE;
                  end else begin
                     pos_x        <= map_x_q;
                     pos_y        <= map_y_q;
                     render_req_q <= 1'b1;
                     state        <= ST_RENDER;
                  end
               end
            end
            ST_RENDER: begin
               // Entered from reset with req low, so raise it here as well.
               if (render_req_q && bus.render_ack) begin
                  render_req_q <= 1'b0;
                  state        <= ST_IDLE;
               end else begin
                  render_req_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.map_rd_req = map_req_q;
   assign bus.map_rd_x   = map_x_q;
   assign bus.map_rd_y   = map_y_q;
   assign bus.render_req = render_req_q;
   assign bus.pos_x      = pos_x;
   assign bus.pos_y      = pos_y;
   assign bus.dir        = dir_q;
   assign bus.busy       = (state != ST_IDLE);
   assign bus.bump       = bump_q;

endmodule

// File: tb/tb_player_controller.sv
// Scoreboard bench: stimulus pushes expected lookups/frames/bumps from a
// grid-walk model; a monitor pops and compares as the DUT presents them.
module tb_player_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   player_controller_if #(.COORD_W(4)) bus ();

   player_controller #(
      .COORD_W(4), .START_X(1), .START_Y(1), .START_DIR(0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int x;
      int y;
      int d;
   } ev_t;

   ev_t exp_frame[$];
   ev_t exp_lk[$];
   ev_t exp_bump[$];

   int checks   = 0;
   int failures = 0;

   int mx = 1, my = 1, md = 0;
   int map_lat    = 1;
   bit map_wall   = 1'b0;
   int render_lat = -1;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=event required=none", name);
   endtask

   initial begin
      bus.btn_fwd      = 1'b0;
      bus.btn_ccw      = 1'b0;
      bus.btn_cw       = 1'b0;
      bus.map_rd_valid = 1'b0;
      bus.map_rd_wall  = 1'b0;
      bus.render_ack   = 1'b0;
   end

   // Map store: answers each request after map_lat cycles.
   int m_l;
   bit m_w;
   initial forever begin
      @(negedge clk);
      if (!rst && bus.map_rd_req && !bus.map_rd_valid) begin
         m_l = map_lat;
         m_w = map_wall;
         repeat (m_l - 1) @(negedge clk);
         bus.map_rd_valid = 1'b1;
         bus.map_rd_wall  = m_w;
         @(negedge clk);
         bus.map_rd_valid = 1'b0;
         bus.map_rd_wall  = 1'b0;
      end
   end

   // Ray caster: acks each frame request after a short delay.
   int r_d;
   initial forever begin
      @(negedge clk);
      if (!rst && bus.render_req && !bus.render_ack) begin
         r_d = (render_lat < 0) ? int'($urandom_range(0, 3)) : render_lat;
         repeat (r_d) @(negedge clk);
         bus.render_ack = 1'b1;
         @(negedge clk);
         bus.render_ack = 1'b0;
      end
   end

   // Monitor
   logic prev_req  = 1'b0;
   logic prev_bump = 1'b0;
   int   hx, hy;
   ev_t  me;
   initial forever begin
      @(negedge clk);
      #1;
      if (rst) begin
         prev_req  = 1'b0;
         prev_bump = 1'b0;
      end else begin
         if (bus.render_req && bus.render_ack) begin
            if (exp_frame.size() == 0) unexpected("frame");
            else begin
               me = exp_frame.pop_front();
               chk("frame_x", int'(bus.pos_x), me.x);
               chk("frame_y", int'(bus.pos_y), me.y);
               chk("frame_dir", int'(bus.dir), me.d);
            end
         end
         if (bus.map_rd_req && !prev_req) begin
            hx = int'(bus.map_rd_x);
            hy = int'(bus.map_rd_y);
            if (exp_lk.size() == 0) unexpected("lookup");
            else begin
               me = exp_lk.pop_front();
               chk("lookup_x", hx, me.x);
               chk("lookup_y", hy, me.y);
            end
         end else if (bus.map_rd_req) begin
            chk("lookup_hold_x", int'(bus.map_rd_x), hx);
            chk("lookup_hold_y", int'(bus.map_rd_y), hy);
         end
         if (bus.bump) begin
            chk("bump_width", int'(prev_bump), 0);
            chk("bump_busy", int'(bus.busy), 0);
            if (exp_bump.size() == 0) unexpected("bump");
            else begin
               me = exp_bump.pop_front();
               chk("bump_pos_x", int'(bus.pos_x), me.x);
               chk("bump_pos_y", int'(bus.pos_y), me.y);
            end
         end
         prev_req  = bus.map_rd_req;
         prev_bump = bus.bump;
      end
   end

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while ((bus.busy || exp_frame.size() != 0 || exp_lk.size() != 0 ||
                  exp_bump.size() != 0) && n < 300);
      chk("idle_timeout", int'(n >= 300), 0);
      chk("idle_pos_x", int'(bus.pos_x), mx);
      chk("idle_pos_y", int'(bus.pos_y), my);
      chk("idle_dir", int'(bus.dir), md);
   endtask

   // kind: 0 fwd, 1 ccw, 2 cw, 3 fwd+cw together
   task automatic press(input int kind, input int lat, input bit wall);
      int tx, ty;
      wait_idle();
      map_lat  = lat;
      map_wall = wall;
      if (kind == 0 || kind == 3) begin
         tx = mx;
         ty = my;
         case (md)
            0: ty = ty - 1;
            1: tx = tx + 1;
            2: ty = ty + 1;
            default: tx = tx - 1;
         endcase
         if (tx < 0 || tx > 15 || ty < 0 || ty > 15) begin
            exp_bump.push_back('{mx, my, md});
         end else begin
            exp_lk.push_back('{tx, ty, md});
            if (wall) exp_bump.push_back('{mx, my, md});
            else begin
               mx = tx;
               my = ty;
               exp_frame.push_back('{mx, my, md});
            end
         end
      end else begin
         md = (kind == 2) ? (md + 1) % 4 : (md + 3) % 4;
         exp_frame.push_back('{mx, my, md});
      end
      @(negedge clk);
      bus.btn_fwd = (kind == 0 || kind == 3);
      bus.btn_ccw = (kind == 1);
      bus.btn_cw  = (kind == 2 || kind == 3);
      @(negedge clk);
      bus.btn_fwd = 1'b0;
      bus.btn_ccw = 1'b0;
      bus.btn_cw  = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      exp_frame.delete();
      exp_lk.delete();
      exp_bump.delete();
      mx = 1;
      my = 1;
      md = 0;
      @(negedge clk);
      rst = 1'b0;
      exp_frame.push_back('{mx, my, md});
      @(negedge clk);
      #1;
      chk("render_after_reset", int'(bus.render_req), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pos_x", int'(bus.pos_x), 1);
      chk("rst_pos_y", int'(bus.pos_y), 1);
      chk("rst_dir", int'(bus.dir), 0);
      chk("rst_map_req", int'(bus.map_rd_req), 0);
      chk("rst_render_req", int'(bus.render_req), 0);
      chk("rst_bump", int'(bus.bump), 0);
      render_lat = 3;
      release_reset();
      render_lat = -1;

      // Full turn clockwise, then one counter-clockwise.
      repeat (4) press(2, 1, 1'b0);
      press(1, 1, 1'b0);

      // Reset while a lookup is outstanding; the late valid must be ignored.
      wait_idle();
      map_lat  = 20;
      map_wall = 1'b0;
      exp_lk.push_back('{0, 1, 3});
      @(negedge clk);
      bus.btn_fwd = 1'b1;
      @(negedge clk);
      bus.btn_fwd = 1'b0;
      n = 0;
      while (!bus.map_rd_req && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("req_before_reset", int'(bus.map_rd_req), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midcheck_req", int'(bus.map_rd_req), 0);
      chk("midcheck_pos_x", int'(bus.pos_x), 1);
      chk("midcheck_pos_y", int'(bus.pos_y), 1);
      release_reset();
      repeat (30) @(negedge clk);
      wait_idle();

      // Moves with and without walls, then both map edges.
      press(2, 1, 1'b0);
      press(0, 5, 1'b0);
      press(2, 1, 1'b0); press(2, 1, 1'b0);
      press(0, 2, 1'b0);
      press(2, 1, 1'b0); press(2, 1, 1'b0);
      press(0, 5, 1'b1);
      press(2, 1, 1'b0); press(2, 1, 1'b0);
      press(0, 1, 1'b0);
      press(0, 1, 1'b0);
      press(2, 1, 1'b0); press(2, 1, 1'b0);
      repeat (15) press(0, 1, 1'b0);
      press(0, 1, 1'b0);
      press(1, 1, 1'b0);
      press(3, 2, 1'b0);
      press(3, 2, 1'b0);

      // A cw edge while rendering is dropped.
      render_lat = 10;
      press(2, 1, 1'b0);
      chk("busy_in_render", int'(bus.busy), 1);
      @(negedge clk);
      bus.btn_cw = 1'b1;
      @(negedge clk);
      bus.btn_cw = 1'b0;
      render_lat = -1;
      wait_idle();

      for (int i = 0; i < 60; i++) begin
         press(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
               ($urandom_range(0, 3) == 0));
      end
      wait_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
